// File: rtl/rename_freelist_mc.sv
// Multi-port physical-register free list: circular buffer of free tags with
// all-or-nothing multi-tag allocation, batched release, Clean restore and sticky overflow.
module rename_freelist_mc #(
  parameter int PREG_WIDE   = 7,
  parameter int DEPTH       = 32,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int INIT_COUNT  = 24,
  parameter int INIT_BASE   = 34,
  parameter int INIT_STRIDE = 4
) (
  input  logic                             Clk,
  input  logic                             Rest,
  input  logic [ALLOC_PORTS-1:0]           AllocReq,
  output logic [ALLOC_PORTS*PREG_WIDE-1:0] AllocPreg,
  output logic                             AllocAck,
  input  logic [FREE_PORTS-1:0]            FreeValid,
  input  logic [FREE_PORTS*PREG_WIDE-1:0]  FreeTag,
  input  logic                             CriqClean,
  output logic [$clog2(DEPTH):0]           FreeCount,
  output logic                             CriqEmpty,
  output logic                             ErrOverflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  // Wide enough to hold a full count plus a whole release batch without wrapping.
  localparam int CW = PW + 3;

  logic [PREG_WIDE-1:0] mem [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;

  logic [CW-1:0] allocRank [ALLOC_PORTS];
  logic [CW-1:0] freeRank  [FREE_PORTS];
  logic [CW-1:0] nA;
  logic [CW-1:0] nF;
  logic [CW-1:0] countExt;
  logic [CW-1:0] grantN;
  logic          freeAccept;

  function automatic logic [PREG_WIDE-1:0] initTag(input int i);
    if (i < INIT_COUNT) return PREG_WIDE'(INIT_BASE + i * INIT_STRIDE);
    return '0;
  endfunction

  always_comb begin
    nA = '0;
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      allocRank[k] = nA;
      nA = nA + CW'(AllocReq[k]);
    end
  end

  always_comb begin
    nF = '0;
    for (int j = 0; j < FREE_PORTS; j++) begin
      freeRank[j] = nF;
      nF = nF + CW'(FreeValid[j]);
    end
  end

  // Look-ahead tags are shown regardless of whether the port is requesting.
  always_comb begin
    AllocPreg = '0;
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      AllocPreg[k*PREG_WIDE +: PREG_WIDE] = mem[IW'(head + PW'(allocRank[k]))];
    end
  end

  assign FreeCount  = tail - head;
  assign CriqEmpty  = (FreeCount == '0);
  assign countExt   = CW'(FreeCount);
  assign AllocAck   = (nA != '0) && (countExt >= nA) && !CriqClean;
  assign grantN     = AllocAck ? nA : '0;
  assign freeAccept = (countExt - grantN + nF) <= CW'(DEPTH);

  // Clean restores the reset image but leaves the sticky error alone.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= initTag(i);
      head        <= '0;
      tail        <= PW'(INIT_COUNT);
      ErrOverflow <= 1'b0;
    end else if (CriqClean) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= initTag(i);
      head <= '0;
      tail <= PW'(INIT_COUNT);
    end else begin
      if (AllocAck) head <= head + PW'(nA);
      if (freeAccept) begin
        for (int j = 0; j < FREE_PORTS; j++) begin
          if (FreeValid[j]) mem[IW'(tail + PW'(freeRank[j]))] <= FreeTag[j*PREG_WIDE +: PREG_WIDE];
        end
        tail <= tail + PW'(nF);
      end else begin
        ErrOverflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rename_freelist_mc.sv
// Directed self-checking bench for rename_freelist_mc with default parameters.
module tb_rename_freelist_mc;

  logic        Clk;
  logic        Rest;
  logic [1:0]  AllocReq;
  logic [13:0] AllocPreg;
  logic        AllocAck;
  logic [1:0]  FreeValid;
  logic [13:0] FreeTag;
  logic        CriqClean;
  logic [5:0]  FreeCount;
  logic        CriqEmpty;
  logic        ErrOverflow;

  int checks = 0;
  int errors = 0;

  logic [6:0] preg0, preg1;
  assign preg0 = AllocPreg[6:0];
  assign preg1 = AllocPreg[13:7];

  rename_freelist_mc dut (
    .Clk(Clk), .Rest(Rest), .AllocReq(AllocReq), .AllocPreg(AllocPreg),
    .AllocAck(AllocAck), .FreeValid(FreeValid), .FreeTag(FreeTag),
    .CriqClean(CriqClean), .FreeCount(FreeCount), .CriqEmpty(CriqEmpty),
    .ErrOverflow(ErrOverflow)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyReset();
    AllocReq = 2'b00; FreeValid = 2'b00; FreeTag = '0; CriqClean = 1'b0;
    Rest = 1'b1;
    #2;
    Rest = 1'b0;
    step();
  endtask

  task automatic test_reset();
    Rest = 1'b1; AllocReq = 2'b11; FreeValid = 2'b00; FreeTag = '0; CriqClean = 1'b0;
    #1;
    checks++; if (FreeCount !== 6'd24) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 24", FreeCount); end
    checks++; if (preg0 !== 7'd34) begin errors++; $display("[TB] FAIL reset_preg0: got %0d expected 34", preg0); end
    checks++; if (preg1 !== 7'd38) begin errors++; $display("[TB] FAIL reset_preg1: got %0d expected 38", preg1); end
    checks++; if (CriqEmpty !== 1'b0) begin errors++; $display("[TB] FAIL reset_empty: got %0b expected 0", CriqEmpty); end
    checks++; if (ErrOverflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", ErrOverflow); end
    AllocReq = 2'b00;
    step();
    Rest = 1'b0;
    step();
    AllocReq = 2'b11;
    step();
    checks++; if (FreeCount !== 6'd22) begin errors++; $display("[TB] FAIL pre_async_count: got %0d expected 22", FreeCount); end
    #3;
    Rest = 1'b1;
    #1;
    checks++; if (FreeCount !== 6'd24) begin errors++; $display("[TB] FAIL async_count: got %0d expected 24", FreeCount); end
    checks++; if (preg0 !== 7'd34) begin errors++; $display("[TB] FAIL async_preg0: got %0d expected 34", preg0); end
    checks++; if (preg1 !== 7'd38) begin errors++; $display("[TB] FAIL async_preg1: got %0d expected 38", preg1); end
    AllocReq = 2'b00;
    Rest = 1'b0;
    step();
  endtask

  task automatic test_alloc();
    applyReset();
    AllocReq = 2'b11;
    #1;
    checks++; if (AllocAck !== 1'b1) begin errors++; $display("[TB] FAIL alloc2_ack: got %0b expected 1", AllocAck); end
    checks++; if (preg0 !== 7'd34) begin errors++; $display("[TB] FAIL alloc2_preg0: got %0d expected 34", preg0); end
    checks++; if (preg1 !== 7'd38) begin errors++; $display("[TB] FAIL alloc2_preg1: got %0d expected 38", preg1); end
    step();
    checks++; if (FreeCount !== 6'd22) begin errors++; $display("[TB] FAIL alloc2_count: got %0d expected 22", FreeCount); end
    checks++; if (preg0 !== 7'd42) begin errors++; $display("[TB] FAIL next_preg0: got %0d expected 42", preg0); end
    checks++; if (preg1 !== 7'd46) begin errors++; $display("[TB] FAIL next_preg1: got %0d expected 46", preg1); end
    AllocReq = 2'b00;
    #1;
    checks++; if (AllocAck !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack: got %0b expected 0", AllocAck); end
    AllocReq = 2'b10;
    #1;
    checks++; if (preg1 !== 7'd42) begin errors++; $display("[TB] FAIL port1_rank0: got %0d expected 42", preg1); end
    checks++; if (AllocAck !== 1'b1) begin errors++; $display("[TB] FAIL port1_ack: got %0b expected 1", AllocAck); end
    step();
    AllocReq = 2'b00;
    #1;
    checks++; if (FreeCount !== 6'd21) begin errors++; $display("[TB] FAIL port1_count: got %0d expected 21", FreeCount); end
    checks++; if (preg0 !== 7'd46) begin errors++; $display("[TB] FAIL port1_next: got %0d expected 46", preg0); end
  endtask

  task automatic test_drain();
    applyReset();
    AllocReq = 2'b11;
    for (int c = 0; c < 12; c++) step();
    AllocReq = 2'b00;
    #1;
    checks++; if (FreeCount !== 6'd0) begin errors++; $display("[TB] FAIL drain_count: got %0d expected 0", FreeCount); end
    checks++; if (CriqEmpty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %0b expected 1", CriqEmpty); end
    AllocReq = 2'b01; FreeValid = 2'b01; FreeTag = {7'd0, 7'd5};
    #1;
    checks++; if (AllocAck !== 1'b0) begin errors++; $display("[TB] FAIL empty_ack: got %0b expected 0", AllocAck); end
    step();
    FreeValid = 2'b00; AllocReq = 2'b11;
    #1;
    checks++; if (FreeCount !== 6'd1) begin errors++; $display("[TB] FAIL refill_count: got %0d expected 1", FreeCount); end
    checks++; if (preg0 !== 7'd5) begin errors++; $display("[TB] FAIL refill_preg0: got %0d expected 5", preg0); end
    checks++; if (AllocAck !== 1'b0) begin errors++; $display("[TB] FAIL short_ack: got %0b expected 0", AllocAck); end
    AllocReq = 2'b01;
    #1;
    checks++; if (AllocAck !== 1'b1) begin errors++; $display("[TB] FAIL single_ack: got %0b expected 1", AllocAck); end
    step();
    AllocReq = 2'b00;
    #1;
    checks++; if (CriqEmpty !== 1'b1) begin errors++; $display("[TB] FAIL redrain_empty: got %0b expected 1", CriqEmpty); end
  endtask

  task automatic test_wrap();
    applyReset();
    AllocReq = 2'b11;
    for (int c = 0; c < 12; c++) step();
    AllocReq = 2'b00;
    for (int c = 0; c < 12; c++) begin
      FreeValid = 2'b11;
      FreeTag = {7'(2 * c + 2), 7'(2 * c + 1)};
      step();
    end
    FreeValid = 2'b00;
    #1;
    checks++; if (FreeCount !== 6'd24) begin errors++; $display("[TB] FAIL wrap_fill: got %0d expected 24", FreeCount); end
    for (int c = 0; c < 8; c++) begin
      AllocReq = 2'b11;
      #1;
      checks++; if (AllocAck !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ack%0d: got %0b expected 1", c, AllocAck); end
      checks++; if (preg0 !== 7'(2 * c + 1)) begin errors++; $display("[TB] FAIL wrap_preg0_%0d: got %0d expected %0d", c, preg0, 2 * c + 1); end
      checks++; if (preg1 !== 7'(2 * c + 2)) begin errors++; $display("[TB] FAIL wrap_preg1_%0d: got %0d expected %0d", c, preg1, 2 * c + 2); end
      step();
    end
    AllocReq = 2'b00;
    #1;
    checks++; if (FreeCount !== 6'd8) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 8", FreeCount); end
  endtask

  task automatic test_overflow();
    applyReset();
    for (int c = 0; c < 4; c++) begin
      FreeValid = 2'b11;
      FreeTag = {7'(101 + 2 * c), 7'(100 + 2 * c)};
      step();
    end
    FreeValid = 2'b00;
    #1;
    checks++; if (FreeCount !== 6'd32) begin errors++; $display("[TB] FAIL full_count: got %0d expected 32", FreeCount); end
    checks++; if (ErrOverflow !== 1'b0) begin errors++; $display("[TB] FAIL full_err: got %0b expected 0", ErrOverflow); end
    FreeValid = 2'b11; FreeTag = {7'd121, 7'd120};
    step();
    FreeValid = 2'b00;
    #1;
    checks++; if (FreeCount !== 6'd32) begin errors++; $display("[TB] FAIL drop_count: got %0d expected 32", FreeCount); end
    checks++; if (ErrOverflow !== 1'b1) begin errors++; $display("[TB] FAIL drop_err: got %0b expected 1", ErrOverflow); end
    FreeValid = 2'b11; FreeTag = {7'd123, 7'd122}; AllocReq = 2'b11;
    #1;
    checks++; if (AllocAck !== 1'b1) begin errors++; $display("[TB] FAIL swap_ack: got %0b expected 1", AllocAck); end
    step();
    FreeValid = 2'b00; AllocReq = 2'b00;
    #1;
    checks++; if (FreeCount !== 6'd32) begin errors++; $display("[TB] FAIL swap_count: got %0d expected 32", FreeCount); end
    checks++; if (preg0 !== 7'd42) begin errors++; $display("[TB] FAIL swap_preg0: got %0d expected 42", preg0); end
  endtask

  task automatic test_clean();
    AllocReq = 2'b01;
    step();
    AllocReq = 2'b00;
    #1;
    checks++; if (FreeCount !== 6'd31) begin errors++; $display("[TB] FAIL mixed_count: got %0d expected 31", FreeCount); end
    CriqClean = 1'b1; AllocReq = 2'b11; FreeValid = 2'b11; FreeTag = {7'd9, 7'd8};
    #1;
    checks++; if (AllocAck !== 1'b0) begin errors++; $display("[TB] FAIL clean_ack: got %0b expected 0", AllocAck); end
    step();
    CriqClean = 1'b0; FreeValid = 2'b00;
    #1;
    checks++; if (FreeCount !== 6'd24) begin errors++; $display("[TB] FAIL clean_count: got %0d expected 24", FreeCount); end
    checks++; if (preg0 !== 7'd34) begin errors++; $display("[TB] FAIL clean_preg0: got %0d expected 34", preg0); end
    checks++; if (preg1 !== 7'd38) begin errors++; $display("[TB] FAIL clean_preg1: got %0d expected 38", preg1); end
    checks++; if (ErrOverflow !== 1'b1) begin errors++; $display("[TB] FAIL clean_err: got %0b expected 1", ErrOverflow); end
    AllocReq = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_drain();
    test_wrap();
    test_overflow();
    test_clean();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
